// File: rtl/bus_initiator_pkg.sv
// Shared definitions for the 8-bit peripheral bus: park address, FSM encoding,
// command record and the VGA register map.
package bus_initiator_pkg;

   localparam logic [7:0] BUS_PARK_ADDR = 8'hFF;

   localparam logic [7:0] VGA_X        = 8'hB0;
   localparam logic [7:0] VGA_Y        = 8'hB1;
   localparam int         VGA_Y_WE_BIT = 7;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WRITE   = 3'd1,
      ST_RD_ADDR = 3'd2,
      ST_RD_WAIT = 3'd3,
      ST_TURN    = 3'd4
   } bus_state_t;

   typedef struct packed {
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
   } bus_cmd_t;

endpackage

// File: rtl/bus_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full/empty
// fall out of a single MSB compare.
module bus_cmd_fifo
   import bus_initiator_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic     CLK,
   input  logic     RESET,
   input  logic     push,
   input  bus_cmd_t push_data,
   input  logic     pop,
   output bus_cmd_t head,
   output logic     full,
   output logic     empty
);
   localparam int AW = $clog2(DEPTH);

   bus_cmd_t      mem [DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/bus_initiator.sv
// Initiator end of the 8-bit peripheral bus: queues commands and issues them
// as registered bus cycles, returning read data on a one-cycle strobe.
module bus_initiator
   import bus_initiator_pkg::*;
#(
   parameter int         FIFO_DEPTH = 2,
   parameter logic [7:0] PARK_ADDR  = BUS_PARK_ADDR
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       CMD_VALID,
   output logic       CMD_READY,
   input  logic       CMD_WE,
   input  logic [7:0] CMD_ADDR,
   input  logic [7:0] CMD_WDATA,
   output logic       RSP_VALID,
   output logic [7:0] RSP_DATA,
   output logic       BUSY,
   output logic [7:0] BUS_ADDR,
   output logic       BUS_WE,
   inout  wire  [7:0] BUS_DATA
);
   bus_state_t state_q, state_nxt;
   bus_cmd_t   head;
   logic       fifo_full, fifo_empty, pop;

   logic [7:0] bus_addr_q, wdata_q, nxt_addr, nxt_wdata;
   logic       bus_we_q, bus_oe, nxt_we, nxt_oe;
   logic       rsp_valid_q;
   logic [7:0] rsp_data_q;

   bus_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .CLK       (CLK),
      .RESET     (RESET),
      .push      (CMD_VALID),
      .push_data ({CMD_WE, CMD_ADDR, CMD_WDATA}),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge CLK) begin
      if (RESET) state_q <= ST_IDLE;
      else       state_q <= state_nxt;
   end

   // IDLE, WRITE and TURN all share the same "issue next or go idle" exit
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_RD_ADDR: state_nxt = ST_RD_WAIT;
         ST_RD_WAIT: state_nxt = ST_TURN;
         default:    state_nxt = fifo_empty ? ST_IDLE : (head.we ? ST_WRITE : ST_RD_ADDR);
      endcase
   end

   // Next values of the bus registers; the default is a parked, released bus
   always_comb begin
      pop       = 1'b0;
      nxt_addr  = PARK_ADDR;
      nxt_we    = 1'b0;
      nxt_oe    = 1'b0;
      nxt_wdata = wdata_q;
      case (state_q)
         ST_RD_ADDR: nxt_addr = bus_addr_q;
         ST_RD_WAIT: ;
         default: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               nxt_addr  = head.addr;
               nxt_we    = head.we;
               nxt_oe    = head.we;
               nxt_wdata = head.wdata;
            end
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         bus_addr_q  <= PARK_ADDR;
         bus_we_q    <= 1'b0;
         bus_oe      <= 1'b0;
         wdata_q     <= 8'h00;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'h00;
      end else begin
         bus_addr_q  <= nxt_addr;
         bus_we_q    <= nxt_we;
         bus_oe      <= nxt_oe;
         wdata_q     <= nxt_wdata;
         rsp_valid_q <= (state_q == ST_RD_WAIT);
         if (state_q == ST_RD_WAIT) rsp_data_q <= BUS_DATA;
      end
   end

   assign BUS_DATA  = bus_oe ? wdata_q : 8'hZZ;
   assign BUS_ADDR  = bus_addr_q;
   assign BUS_WE    = bus_we_q;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_DATA  = rsp_data_q;
   assign CMD_READY = !fifo_full;
   assign BUSY      = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator with a responder model holding the VGA
// register bank at B0-B3 (B2 reads a fixed 5C).
module tb_bus_initiator;
   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       cmd_valid = 1'b0, cmd_we = 1'b0;
   logic [7:0] cmd_addr = 8'h00, cmd_wdata = 8'h00;
   logic       cmd_ready, rsp_valid, busy, bus_we;
   logic [7:0] rsp_data, bus_addr;
   wire  [7:0] bus_data;

   int tests = 0, fails = 0;
   int contention = 0, rsp_pulses = 0;

   bus_initiator #(.FIFO_DEPTH(2), .PARK_ADDR(8'hFF)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .CMD_VALID (cmd_valid),
      .CMD_READY (cmd_ready),
      .CMD_WE    (cmd_we),
      .CMD_ADDR  (cmd_addr),
      .CMD_WDATA (cmd_wdata),
      .RSP_VALID (rsp_valid),
      .RSP_DATA  (rsp_data),
      .BUSY      (busy),
      .BUS_ADDR  (bus_addr),
      .BUS_WE    (bus_we),
      .BUS_DATA  (bus_data)
   );

   always #5 CLK = ~CLK;

   // Responder: registers its drive enable one edge after seeing its address
   logic [7:0] vga_x = 8'h00, vga_y = 8'h00, rsp_q = 8'h00;
   logic       rsp_oe = 1'b0;
   logic       fb_we;
   assign fb_we    = vga_y[7];
   assign bus_data = rsp_oe ? rsp_q : 8'hZZ;

   always @(posedge CLK) begin
      if (bus_addr[7:2] == 6'b101100) begin
         if (bus_we) begin
            rsp_oe <= 1'b0;
            if (bus_addr == 8'hB0) vga_x <= bus_data;
            if (bus_addr == 8'hB1) vga_y <= bus_data;
         end else begin
            rsp_oe <= 1'b1;
            case (bus_addr[1:0])
               2'd0:    rsp_q <= vga_x;
               2'd1:    rsp_q <= vga_y;
               2'd2:    rsp_q <= 8'h5C;
               default: rsp_q <= 8'h00;
            endcase
         end
      end else begin
         rsp_oe <= 1'b0;
      end
   end

   always @(negedge CLK) begin
      if (dut.bus_oe && rsp_oe) contention++;
      if (rsp_valid) rsp_pulses++;
   end

   task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Returns in the cycle right after the accepting edge
   task automatic send(input logic we, input logic [7:0] a, input logic [7:0] d);
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
      for (int i = 0; i < 20 && !cmd_ready; i++) tick;
      chk("send_rdy", 8'(cmd_ready), 8'h01);
      tick;
      cmd_valid = 1'b0;
   endtask

   logic [7:0] t4_addr [5] = '{8'hB1, 8'hB1, 8'hFF, 8'hB0, 8'hFF};
   logic       t4_we   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   int         pulses0;

   initial begin
      tick; tick;
      chk("rst_addr", bus_addr, 8'hFF);
      chk("rst_we", 8'(bus_we), 8'h00);
      chk("rst_oe", 8'(dut.bus_oe), 8'h00);
      chk("rst_rspv", 8'(rsp_valid), 8'h00);
      chk("rst_rspd", rsp_data, 8'h00);
      chk("rst_rdy", 8'(cmd_ready), 8'h01);
      chk("rst_busy", 8'(busy), 8'h00);
      RESET = 1'b0;
      tick;

      // 1: single write
      send(1'b1, 8'hB0, 8'h2A);
      chk("w_busy", 8'(busy), 8'h01);
      tick;
      chk("w_addr", bus_addr, 8'hB0);
      chk("w_we", 8'(bus_we), 8'h01);
      chk("w_oe", 8'(dut.bus_oe), 8'h01);
      chk("w_data", bus_data, 8'h2A);
      tick;
      chk("w_park", bus_addr, 8'hFF);
      chk("w_we0", 8'(bus_we), 8'h00);
      chk("w_rel", 8'(dut.bus_oe), 8'h00);
      chk("w_vgax", vga_x, 8'h2A);

      // 2: read of B2
      send(1'b0, 8'hB2, 8'h00);
      tick;
      chk("r_addr1", bus_addr, 8'hB2);
      chk("r_oe1", 8'(dut.bus_oe), 8'h00);
      chk("r_v1", 8'(rsp_valid), 8'h00);
      tick;
      chk("r_addr2", bus_addr, 8'hB2);
      chk("r_v2", 8'(rsp_valid), 8'h00);
      tick;
      chk("r_v3", 8'(rsp_valid), 8'h01);
      chk("r_data", rsp_data, 8'h5C);
      chk("r_park", bus_addr, 8'hFF);
      tick;
      chk("r_v4", 8'(rsp_valid), 8'h00);
      chk("r_hold", rsp_data, 8'h5C);
      chk("r_busy", 8'(busy), 8'h00);

      // 3: read of B3 keeps the FSM busy while three writes fill the FIFO
      send(1'b0, 8'hB3, 8'h00);
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h10; cmd_wdata = 8'hA1;
      tick;
      chk("f_rdy1", 8'(cmd_ready), 8'h01);
      cmd_addr = 8'h11; cmd_wdata = 8'hA2;
      tick;
      chk("f_full1", 8'(cmd_ready), 8'h00);
      cmd_addr = 8'h12; cmd_wdata = 8'hA3;
      tick;
      chk("f_full2", 8'(cmd_ready), 8'h00);
      chk("f_rspv", 8'(rsp_valid), 8'h01);
      chk("f_rspd", rsp_data, 8'h00);
      tick;
      chk("f_rdy2", 8'(cmd_ready), 8'h01);
      chk("f_a1", bus_addr, 8'h10);
      chk("f_d1", bus_data, 8'hA1);
      tick;
      cmd_valid = 1'b0;
      chk("f_a2", bus_addr, 8'h11);
      chk("f_d2", bus_data, 8'hA2);
      tick;
      chk("f_a3", bus_addr, 8'h12);
      chk("f_d3", bus_data, 8'hA3);
      tick;
      chk("f_park", bus_addr, 8'hFF);
      chk("f_busy", 8'(busy), 8'h00);

      // 4: read B1 then write B0<=11; the write waits out the turnaround
      send(1'b0, 8'hB1, 8'h00);
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'hB0; cmd_wdata = 8'h11;
      tick;
      cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("rw_addr%0d", i), bus_addr, t4_addr[i]);
         chk($sformatf("rw_we%0d", i), 8'(bus_we), 8'(t4_we[i]));
         tick;
      end
      chk("rw_vgax", vga_x, 8'h11);
      chk("rw_contention", 8'(contention), 8'h00);

      // 5: reset while in RD_WAIT with a write queued
      send(1'b0, 8'hB2, 8'h00);
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'hB0; cmd_wdata = 8'h77;
      tick;
      cmd_valid = 1'b0;
      tick;
      chk("rs_busy_pre", 8'(busy), 8'h01);
      pulses0 = rsp_pulses;
      RESET = 1'b1;
      tick;
      chk("rs_park", bus_addr, 8'hFF);
      chk("rs_oe", 8'(dut.bus_oe), 8'h00);
      chk("rs_rspv", 8'(rsp_valid), 8'h00);
      chk("rs_rdy", 8'(cmd_ready), 8'h01);
      chk("rs_busy", 8'(busy), 8'h00);
      RESET = 1'b0;
      for (int i = 0; i < 4; i++) tick;
      chk("rs_nopulse", 8'(rsp_pulses - pulses0), 8'h00);
      chk("rs_nowrite", vga_x, 8'h11);
      chk("rs_idle", bus_addr, 8'hFF);

      // 6: program the VGA bank and read back Y
      send(1'b1, 8'hB0, 8'h10);
      send(1'b1, 8'hB1, 8'h85);
      send(1'b0, 8'hB1, 8'h00);
      for (int i = 0; i < 20 && !rsp_valid; i++) tick;
      chk("v_rspv", 8'(rsp_valid), 8'h01);
      chk("v_rspd", rsp_data, 8'h85);
      chk("v_x", vga_x, 8'h10);
      chk("v_fbwe", 8'(fb_we), 8'h01);
      chk("v_contention", 8'(contention), 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
